// File: rtl/axi_common.sv
// rtl/axi_common.sv - shared AXI field types and their encodings
package axi_common;

    typedef logic [1:0] burst_t;
    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    typedef logic [3:0] cache_t;
    localparam cache_t CACHE_DEVICE_NB = 4'b0000;
    localparam cache_t CACHE_BUFFERABLE = 4'b0001;
    localparam cache_t CACHE_MODIFIABLE = 4'b0010;

    typedef logic [2:0] prot_t;
    localparam prot_t PROT_PRIVILEGED  = 3'b001;
    localparam prot_t PROT_NONSECURE   = 3'b010;
    localparam prot_t PROT_INSTRUCTION = 3'b100;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_channel.sv
// rtl/axi_channel.sv - full AXI4 bundle with master and slave views
interface axi_channel #(
    parameter int ID_WIDTH      = 8,
    parameter int ADDR_WIDTH    = 48,
    parameter int DATA_WIDTH    = 64,
    parameter int AW_USER_WIDTH = 1,
    parameter int AR_USER_WIDTH = 1,
    parameter int W_USER_WIDTH  = 1,
    parameter int R_USER_WIDTH  = 1,
    parameter int B_USER_WIDTH  = 1
);
    import axi_common::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]      aw_id;
    logic [ADDR_WIDTH-1:0]    aw_addr;
    logic [7:0]               aw_len;
    logic [2:0]               aw_size;
    burst_t                   aw_burst;
    logic                     aw_lock;
    cache_t                   aw_cache;
    prot_t                    aw_prot;
    logic [3:0]               aw_qos;
    logic [3:0]               aw_region;
    logic [AW_USER_WIDTH-1:0] aw_user;
    logic                     aw_valid;
    logic                     aw_ready;

    logic [DATA_WIDTH-1:0]    w_data;
    logic [STRB_WIDTH-1:0]    w_strb;
    logic                     w_last;
    logic [W_USER_WIDTH-1:0]  w_user;
    logic                     w_valid;
    logic                     w_ready;

    logic [ID_WIDTH-1:0]      b_id;
    resp_t                    b_resp;
    logic [B_USER_WIDTH-1:0]  b_user;
    logic                     b_valid;
    logic                     b_ready;

    logic [ID_WIDTH-1:0]      ar_id;
    logic [ADDR_WIDTH-1:0]    ar_addr;
    logic [7:0]               ar_len;
    logic [2:0]               ar_size;
    burst_t                   ar_burst;
    logic                     ar_lock;
    cache_t                   ar_cache;
    prot_t                    ar_prot;
    logic [3:0]               ar_qos;
    logic [3:0]               ar_region;
    logic [AR_USER_WIDTH-1:0] ar_user;
    logic                     ar_valid;
    logic                     ar_ready;

    logic [ID_WIDTH-1:0]      r_id;
    logic [DATA_WIDTH-1:0]    r_data;
    resp_t                    r_resp;
    logic                     r_last;
    logic [R_USER_WIDTH-1:0]  r_user;
    logic                     r_valid;
    logic                     r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_skid_buffer.sv
// rtl/axi_skid_buffer.sv - two-entry skid buffer with fully registered valid, ready and data
module axi_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        in_fire      = in_valid && in_ready_q;
        out_fire     = main_valid_q && out_ready;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        // in_ready_q mirrors !skid_valid_q, so no input can arrive while skid is full
        if (skid_valid_q) begin
            if (out_fire) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Payload is don't-care while the matching valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/axi_modport_slice.sv
// rtl/axi_modport_slice.sv - AXI4 register slice, one skid buffer per channel.
// AXI_MODPORT_SLICE_USER_EN: store and forward *_user fields; otherwise they are driven 0.
module axi_modport_slice
    import axi_common::*;
#(
    parameter int ID_WIDTH      = 8,
    parameter int ADDR_WIDTH    = 48,
    parameter int DATA_WIDTH    = 64,
    parameter int AW_USER_WIDTH = 1,
    parameter int AR_USER_WIDTH = 1,
    parameter int W_USER_WIDTH  = 1,
    parameter int R_USER_WIDTH  = 1,
    parameter int B_USER_WIDTH  = 1
) (
    input  logic       clk,
    input  logic       rst,
    axi_channel.slave  up,
    axi_channel.master dn
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + $bits(burst_t) + 1
                        + $bits(cache_t) + $bits(prot_t) + 4 + 4;
    localparam int WB_W = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int RB_W = ID_WIDTH + DATA_WIDTH + $bits(resp_t) + 1;
    localparam int BB_W = ID_WIDTH + $bits(resp_t);

`ifdef AXI_MODPORT_SLICE_USER_EN
    localparam int AW_PW = AX_W + AW_USER_WIDTH;
    localparam int AR_PW = AX_W + AR_USER_WIDTH;
    localparam int W_PW  = WB_W + W_USER_WIDTH;
    localparam int R_PW  = RB_W + R_USER_WIDTH;
    localparam int B_PW  = BB_W + B_USER_WIDTH;
`else
    localparam int AW_PW = AX_W;
    localparam int AR_PW = AX_W;
    localparam int W_PW  = WB_W;
    localparam int R_PW  = RB_W;
    localparam int B_PW  = BB_W;
`endif

    logic [AX_W-1:0]  aw_base_in, aw_base_out, ar_base_in, ar_base_out;
    logic [WB_W-1:0]  w_base_in, w_base_out;
    logic [RB_W-1:0]  r_base_in, r_base_out;
    logic [BB_W-1:0]  b_base_in, b_base_out;
    logic [AW_PW-1:0] aw_in, aw_out;
    logic [AR_PW-1:0] ar_in, ar_out;
    logic [W_PW-1:0]  w_in, w_out;
    logic [R_PW-1:0]  r_in, r_out;
    logic [B_PW-1:0]  b_in, b_out;

    assign aw_base_in = {up.aw_id, up.aw_addr, up.aw_len, up.aw_size, up.aw_burst,
                         up.aw_lock, up.aw_cache, up.aw_prot, up.aw_qos, up.aw_region};
    assign {dn.aw_id, dn.aw_addr, dn.aw_len, dn.aw_size, dn.aw_burst,
            dn.aw_lock, dn.aw_cache, dn.aw_prot, dn.aw_qos, dn.aw_region} = aw_base_out;

    assign ar_base_in = {up.ar_id, up.ar_addr, up.ar_len, up.ar_size, up.ar_burst,
                         up.ar_lock, up.ar_cache, up.ar_prot, up.ar_qos, up.ar_region};
    assign {dn.ar_id, dn.ar_addr, dn.ar_len, dn.ar_size, dn.ar_burst,
            dn.ar_lock, dn.ar_cache, dn.ar_prot, dn.ar_qos, dn.ar_region} = ar_base_out;

    assign w_base_in = {up.w_data, up.w_strb, up.w_last};
    assign {dn.w_data, dn.w_strb, dn.w_last} = w_base_out;

    assign r_base_in = {dn.r_id, dn.r_data, dn.r_resp, dn.r_last};
    assign {up.r_id, up.r_data, up.r_resp, up.r_last} = r_base_out;

    assign b_base_in = {dn.b_id, dn.b_resp};
    assign {up.b_id, up.b_resp} = b_base_out;

`ifdef AXI_MODPORT_SLICE_USER_EN
    assign aw_in = {up.aw_user, aw_base_in};
    assign ar_in = {up.ar_user, ar_base_in};
    assign w_in  = {up.w_user, w_base_in};
    assign r_in  = {dn.r_user, r_base_in};
    assign b_in  = {dn.b_user, b_base_in};
    assign {dn.aw_user, aw_base_out} = aw_out;
    assign {dn.ar_user, ar_base_out} = ar_out;
    assign {dn.w_user, w_base_out}   = w_out;
    assign {up.r_user, r_base_out}   = r_out;
    assign {up.b_user, b_base_out}   = b_out;
`else
    assign aw_in       = aw_base_in;
    assign ar_in       = ar_base_in;
    assign w_in        = w_base_in;
    assign r_in        = r_base_in;
    assign b_in        = b_base_in;
    assign aw_base_out = aw_out;
    assign ar_base_out = ar_out;
    assign w_base_out  = w_out;
    assign r_base_out  = r_out;
    assign b_base_out  = b_out;
    assign dn.aw_user  = {AW_USER_WIDTH{1'b0}};
    assign dn.ar_user  = {AR_USER_WIDTH{1'b0}};
    assign dn.w_user   = {W_USER_WIDTH{1'b0}};
    assign up.r_user   = {R_USER_WIDTH{1'b0}};
    assign up.b_user   = {B_USER_WIDTH{1'b0}};
`endif

    axi_skid_buffer #(.WIDTH(AW_PW)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(up.aw_valid), .in_ready(up.aw_ready), .in_data(aw_in),
        .out_valid(dn.aw_valid), .out_ready(dn.aw_ready), .out_data(aw_out)
    );

    axi_skid_buffer #(.WIDTH(W_PW)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(up.w_valid), .in_ready(up.w_ready), .in_data(w_in),
        .out_valid(dn.w_valid), .out_ready(dn.w_ready), .out_data(w_out)
    );

    axi_skid_buffer #(.WIDTH(AR_PW)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(up.ar_valid), .in_ready(up.ar_ready), .in_data(ar_in),
        .out_valid(dn.ar_valid), .out_ready(dn.ar_ready), .out_data(ar_out)
    );

    axi_skid_buffer #(.WIDTH(R_PW)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(dn.r_valid), .in_ready(dn.r_ready), .in_data(r_in),
        .out_valid(up.r_valid), .out_ready(up.r_ready), .out_data(r_out)
    );

    axi_skid_buffer #(.WIDTH(B_PW)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(dn.b_valid), .in_ready(dn.b_ready), .in_data(b_in),
        .out_valid(up.b_valid), .out_ready(up.b_ready), .out_data(b_out)
    );

endmodule

// File: tb/tb_axi_modport_slice.sv
// tb/tb_axi_modport_slice.sv - queue-model bench for axi_modport_slice (channels 0..4 = AW, W, AR, R, B)
module tb_axi_modport_slice;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_channel up_if ();
    axi_channel dn_if ();

    axi_modport_slice dut (.clk(clk), .rst(rst), .up(up_if), .dn(dn_if));

`ifdef AXI_MODPORT_SLICE_USER_EN
    localparam logic EXP_U = 1'b1;
`else
    localparam logic EXP_U = 1'b0;
`endif

    logic         in_v  [5];
    logic [127:0] in_d  [5];
    logic         out_r [5];
    logic         in_r  [5];
    logic         out_v [5];
    logic [127:0] out_d [5];

    assign up_if.aw_valid = in_v[0];
    assign up_if.w_valid  = in_v[1];
    assign up_if.ar_valid = in_v[2];
    assign dn_if.r_valid  = in_v[3];
    assign dn_if.b_valid  = in_v[4];
    assign dn_if.aw_ready = out_r[0];
    assign dn_if.w_ready  = out_r[1];
    assign dn_if.ar_ready = out_r[2];
    assign up_if.r_ready  = out_r[3];
    assign up_if.b_ready  = out_r[4];
    assign in_r[0] = up_if.aw_ready;
    assign in_r[1] = up_if.w_ready;
    assign in_r[2] = up_if.ar_ready;
    assign in_r[3] = dn_if.r_ready;
    assign in_r[4] = dn_if.b_ready;
    assign out_v[0] = dn_if.aw_valid;
    assign out_v[1] = dn_if.w_valid;
    assign out_v[2] = dn_if.ar_valid;
    assign out_v[3] = up_if.r_valid;
    assign out_v[4] = up_if.b_valid;

    assign {up_if.aw_user, up_if.aw_id, up_if.aw_addr, up_if.aw_len, up_if.aw_size, up_if.aw_burst,
            up_if.aw_lock, up_if.aw_cache, up_if.aw_prot, up_if.aw_qos, up_if.aw_region} = in_d[0][85:0];
    assign {up_if.w_user, up_if.w_data, up_if.w_strb, up_if.w_last} = in_d[1][73:0];
    assign {up_if.ar_user, up_if.ar_id, up_if.ar_addr, up_if.ar_len, up_if.ar_size, up_if.ar_burst,
            up_if.ar_lock, up_if.ar_cache, up_if.ar_prot, up_if.ar_qos, up_if.ar_region} = in_d[2][85:0];
    assign {dn_if.r_user, dn_if.r_id, dn_if.r_data, dn_if.r_resp, dn_if.r_last} = in_d[3][75:0];
    assign {dn_if.b_user, dn_if.b_id, dn_if.b_resp} = in_d[4][10:0];

    assign out_d[0] = {42'd0, dn_if.aw_user, dn_if.aw_id, dn_if.aw_addr, dn_if.aw_len, dn_if.aw_size,
                       dn_if.aw_burst, dn_if.aw_lock, dn_if.aw_cache, dn_if.aw_prot, dn_if.aw_qos, dn_if.aw_region};
    assign out_d[1] = {54'd0, dn_if.w_user, dn_if.w_data, dn_if.w_strb, dn_if.w_last};
    assign out_d[2] = {42'd0, dn_if.ar_user, dn_if.ar_id, dn_if.ar_addr, dn_if.ar_len, dn_if.ar_size,
                       dn_if.ar_burst, dn_if.ar_lock, dn_if.ar_cache, dn_if.ar_prot, dn_if.ar_qos, dn_if.ar_region};
    assign out_d[3] = {52'd0, up_if.r_user, up_if.r_id, up_if.r_data, up_if.r_resp, up_if.r_last};
    assign out_d[4] = {117'd0, up_if.b_user, up_if.b_id, up_if.b_resp};

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [127:0] mq [5][$];
    int  delivered [5];
    logic fire_in [5];
    logic rst_prev = 1'b1;

    function automatic int pw(input int c);
        case (c)
            0, 2:    return 86;
            1:       return 74;
            3:       return 76;
            default: return 11;
        endcase
    endfunction

    // What the downstream side must see for a beat offered upstream.
    function automatic logic [127:0] expect_beat(input int c, input logic [127:0] d);
        logic [127:0] r;
        r = d & ((128'd1 << pw(c)) - 128'd1);
        if (!EXP_U) r[pw(c)-1] = 1'b0;
        return r;
    endfunction

    function automatic logic [127:0] ax_beat(input logic u, input logic [7:0] id,
                                             input logic [47:0] addr, input logic [7:0] len);
        return {42'd0, u, id, addr, len, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0};
    endfunction

    function automatic logic [127:0] w_beat(input logic [63:0] d);
        return {54'd0, 1'b0, d, 8'hFF, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    // Apply the coming clock edge to the model, then compare DUT outputs after it.
    task automatic tick();
        logic fo;
        for (int c = 0; c < 5; c++) begin
            fire_in[c] = in_v[c] && in_r[c];
            fo = out_v[c] && out_r[c];
            if (rst) begin
                mq[c].delete();
            end else begin
                if (fo && mq[c].size() > 0) begin
                    void'(mq[c].pop_front());
                    delivered[c]++;
                end
                if (fire_in[c]) mq[c].push_back(expect_beat(c, in_d[c]));
            end
        end
        rst_prev = rst;
        @(negedge clk);
        cycle++;
        for (int c = 0; c < 5; c++) begin
            if (rst_prev) begin
                chk($sformatf("rst_ch%0d_ready", c), 128'(in_r[c]), 128'd0);
                chk($sformatf("rst_ch%0d_valid", c), 128'(out_v[c]), 128'd0);
            end else begin
                chk($sformatf("ch%0d_ready", c), 128'(in_r[c]), 128'(mq[c].size() < 2));
                chk($sformatf("ch%0d_valid", c), 128'(out_v[c]), 128'(mq[c].size() > 0));
                if (out_v[c] && mq[c].size() > 0)
                    chk($sformatf("ch%0d_data", c), out_d[c], mq[c][0]);
            end
        end
    endtask

    logic [63:0] rd [32];
    logic        rl [32];
    int          rc [32];
    int          n;
    logic        cfire;
    int          gen [5];
    int          budget;
    logic        done;

    initial begin
        for (int c = 0; c < 5; c++) begin
            in_v[c] = 1'b0; in_d[c] = '0; out_r[c] = 1'b0; delivered[c] = 0;
        end

        // Reset held three cycles with an AW offered throughout.
        @(negedge clk);
        rst = 1'b1;
        in_v[0] = 1'b1; in_d[0] = ax_beat(1'b0, 8'd1, 48'h40, 8'd0);
        repeat (3) tick();
        chk("rst_aw_ready_lit", 128'(up_if.aw_ready), 128'd0);
        chk("rst_dn_aw_valid_lit", 128'(dn_if.aw_valid), 128'd0);
        rst = 1'b0; in_v[0] = 1'b0;
        tick();
        chk("post_rst_ready_lit", {123'd0, up_if.aw_ready, up_if.w_ready, up_if.ar_ready,
                                   dn_if.r_ready, dn_if.b_ready}, 128'h1F);
        chk("post_rst_no_aw_lit", 128'(dn_if.aw_valid), 128'd0);
        tick();
        chk("post_rst_no_aw_lit2", 128'(dn_if.aw_valid), 128'd0);

        // Single write: AW + W forward, B back.
        in_v[0] = 1'b1; in_d[0] = ax_beat(1'b1, 8'd3, 48'h1000, 8'd0);
        in_v[1] = 1'b1; in_d[1] = {54'd0, 1'b1, 64'hDEADBEEF_00000001, 8'hFF, 1'b1};
        tick();
        in_v[0] = 1'b0; in_v[1] = 1'b0;
        chk("wr_aw_valid_lit", 128'(dn_if.aw_valid), 128'd1);
        chk("wr_aw_addr_lit", 128'(dn_if.aw_addr), 128'h1000);
        chk("wr_aw_id_lit", 128'(dn_if.aw_id), 128'd3);
        chk("wr_aw_len_burst_lit", {118'd0, dn_if.aw_len, dn_if.aw_burst}, 128'h001);
        chk("wr_aw_user_lit", 128'(dn_if.aw_user), 128'(EXP_U));
        chk("wr_w_data_lit", 128'(dn_if.w_data), 128'hDEADBEEF_00000001);
        chk("wr_w_strb_last_lit", {119'd0, dn_if.w_strb, dn_if.w_last}, 128'h1FF);
        out_r[0] = 1'b1; out_r[1] = 1'b1;
        tick();
        chk("wr_aw_drained_lit", 128'(dn_if.aw_valid), 128'd0);
        in_v[4] = 1'b1; in_d[4] = {117'd0, 1'b0, 8'd3, 2'b00};
        tick();
        in_v[4] = 1'b0;
        chk("wr_b_valid_lit", 128'(up_if.b_valid), 128'd1);
        chk("wr_b_id_resp_lit", {118'd0, up_if.b_id, up_if.b_resp}, 128'h00C);
        out_r[4] = 1'b1;
        tick();
        chk("wr_b_drained_lit", 128'(up_if.b_valid), 128'd0);

        // Streaming read: one AR, sixteen back-to-back R beats.
        out_r[2] = 1'b1;
        in_v[2] = 1'b1; in_d[2] = ax_beat(1'b0, 8'd5, 48'h2000, 8'd15);
        tick();
        in_v[2] = 1'b0;
        chk("rd_ar_len_lit", 128'(dn_if.ar_len), 128'd15);
        tick();
        out_r[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                in_v[3] = 1'b1;
                in_d[3] = {52'd0, 1'b0, 8'd5, 64'(i), 2'b00, (i == 15)};
            end else begin
                in_v[3] = 1'b0;
            end
            tick();
            if (up_if.r_valid && n < 32) begin
                rd[n] = up_if.r_data; rl[n] = up_if.r_last; rc[n] = cycle; n++;
            end
        end
        chk("rd_beat_count_lit", 128'(n), 128'd16);
        for (int k = 0; k < 16 && k < n; k++) begin
            chk($sformatf("rd_data%0d_lit", k), 128'(rd[k]), 128'(k));
            chk($sformatf("rd_last%0d_lit", k), 128'(rl[k]), 128'(k == 15));
        end
        if (n >= 16) chk("rd_no_bubbles_lit", 128'(rc[15] - rc[0]), 128'd15);

        // Backpressure on W: two beats held, third stalls.
        out_r[1] = 1'b0;
        in_v[1] = 1'b1; in_d[1] = w_beat(64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        chk("bp_ready_after_a_lit", 128'(up_if.w_ready), 128'd1);
        in_d[1] = w_beat(64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        chk("bp_ready_on_c_lit", 128'(up_if.w_ready), 128'd0);
        in_d[1] = w_beat(64'hCCCC_CCCC_CCCC_CCCC);
        repeat (2) begin
            tick();
            chk("bp_stall_ready_lit", 128'(up_if.w_ready), 128'd0);
            chk("bp_stall_data_lit", 128'(dn_if.w_data), 128'hAAAA_AAAA_AAAA_AAAA);
        end
        out_r[1] = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (dn_if.w_valid && n < 32) begin rd[n] = dn_if.w_data; n++; end
            cfire = in_v[1] && up_if.w_ready;
            tick();
            if (cfire) in_v[1] = 1'b0;
        end
        chk("bp_count_lit", 128'(n), 128'd3);
        if (n >= 3) begin
            chk("bp_order_a_lit", 128'(rd[0]), 128'hAAAA_AAAA_AAAA_AAAA);
            chk("bp_order_b_lit", 128'(rd[1]), 128'hBBBB_BBBB_BBBB_BBBB);
            chk("bp_order_c_lit", 128'(rd[2]), 128'hCCCC_CCCC_CCCC_CCCC);
        end

        // Random valid/ready on all channels, 1000 beats each.
        for (int c = 0; c < 5; c++) begin
            in_v[c] = 1'b0; gen[c] = 0; delivered[c] = 0;
        end
        tick();
        for (int c = 0; c < 5; c++) delivered[c] = 0;
        budget = 0;
        done = 1'b0;
        while (!done && budget < 20000) begin
            for (int c = 0; c < 5; c++) begin
                if (!in_v[c] || fire_in[c]) begin
                    if (gen[c] < 1000 && $urandom_range(3) != 0) begin
                        in_v[c] = 1'b1;
                        in_d[c] = {$urandom, $urandom, $urandom, $urandom};
                        gen[c]++;
                    end else begin
                        in_v[c] = 1'b0;
                    end
                end
                out_r[c] = ($urandom_range(2) != 0);
            end
            tick();
            budget++;
            done = 1'b1;
            for (int c = 0; c < 5; c++)
                if (delivered[c] < 1000) done = 1'b0;
        end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rand_ch%0d_delivered", c), 128'(delivered[c]), 128'd1000);
            chk($sformatf("rand_ch%0d_leftover", c), 128'(mq[c].size()), 128'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
